// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcode classes, memory opcodes and the
// per-stage control record carried through EX, MEM and WB.
package ctrl_pkg;

  localparam logic [2:0] MEM_DATA = 3'b000;
  localparam logic [2:0] REG_DATA = 3'b001;
  localparam logic [2:0] ANDOR    = 3'b010;
  localparam logic [2:0] NOTXOR   = 3'b011;
  localparam logic [2:0] SHIFT    = 3'b100;
  localparam logic [2:0] ADDSUB   = 3'b101;
  localparam logic [2:0] DIV      = 3'b110;

  localparam logic [3:0] OP_LDM = 4'b0000;
  localparam logic [3:0] OP_STM = 4'b0001;

  localparam int CTRL_RD_W = 3;

  typedef struct packed {
    logic                 valid;
    logic                 reg_wr;
    logic                 mem_wr;
    logic                 is_load;
    logic [CTRL_RD_W-1:0] rd;
  } pipe_ctrl_t;

  // Class 3'b111 is the only undecoded opcode group.
  function automatic logic op_decoded(input logic [3:0] op);
    case (op[3:1])
      MEM_DATA, REG_DATA, ANDOR, NOTXOR, SHIFT, ADDSUB, DIV: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: async clear, synchronous kill (wins over load),
// load enable.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (kill) q <= '0;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/ctrl_wb_pipe.sv
// Control back end: carries decoder write signals through EX/MEM/WB, issues the
// memory and register-file write strobes and flags RAW hazards to ID.
// Optional PIPE_PERF_EN adds retired/bubble counters.
module ctrl_wb_pipe
  import ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [3:0]            id_opcode,
  input  logic                  id_reg_signal_write,
  input  logic                  id_mem_signal_write,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [DATA_W-1:0]     ex_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [MEM_ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  hazard,
`ifdef PIPE_PERF_EN
  output logic [15:0]           retired_cnt,
  output logic [15:0]           bubble_cnt,
`endif
  output logic                  illegal_op
);

  localparam int CW = $bits(pipe_ctrl_t);
  localparam int MW = CW + 2*DATA_W + MEM_ADDR_W;
  localparam int WW = CW + DATA_W;

  pipe_ctrl_t            id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
  logic [DATA_W-1:0]     mem_result, mem_store_data, wb_result;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic                  id_undef;

  assign id_undef = !op_decoded(id_opcode);

  // Undecoded opcodes become NOPs so no X or stray write strobe escapes.
  always_comb begin
    id_ctrl       = '0;
    id_ctrl.valid = id_valid;
    id_ctrl.rd    = CTRL_RD_W'(id_rd);
    if (!id_undef) begin
      id_ctrl.reg_wr  = id_reg_signal_write;
      id_ctrl.mem_wr  = id_mem_signal_write;
      id_ctrl.is_load = (id_opcode == OP_LDM);
    end
  end

  pipe_stage_reg #(.W(CW)) u_ex (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .kill(flush | stall),
    .d(id_ctrl), .q(ex_ctrl)
  );

  pipe_stage_reg #(.W(MW)) u_mem (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .kill(flush),
    .d({ex_ctrl, ex_result, ex_store_data, ex_mem_addr}),
    .q({mem_ctrl, mem_result, mem_store_data, mem_addr_q})
  );

  pipe_stage_reg #(.W(WW)) u_wb (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .kill(1'b0),
    .d({mem_ctrl, mem_result}),
    .q({wb_ctrl, wb_result})
  );

  assign mem_we    = mem_ctrl.valid & mem_ctrl.mem_wr;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_store_data;

  // Synchronous read data lands while the load occupies WB.
  assign rf_we    = wb_ctrl.valid & wb_ctrl.reg_wr;
  assign rf_waddr = REG_ADDR_W'(wb_ctrl.rd);
  assign rf_wdata = wb_ctrl.is_load ? mem_rdata : wb_result;

  logic unused_wb_mem_wr;
  assign unused_wb_mem_wr = wb_ctrl.mem_wr;

  function automatic logic raw_hit(input pipe_ctrl_t s,
                                   input logic [REG_ADDR_W-1:0] a,
                                   input logic [REG_ADDR_W-1:0] b);
    logic [REG_ADDR_W-1:0] rd;
    rd = REG_ADDR_W'(s.rd);
    return s.valid & s.reg_wr & ((rd == a) | (rd == b));
  endfunction

  // WB is not compared: the register file writes through to same-cycle reads.
  assign hazard = id_valid & (raw_hit(ex_ctrl,  id_rs1, id_rs2) |
                              raw_hit(mem_ctrl, id_rs1, id_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   illegal_op <= 1'b0;
    else if (id_valid & id_undef) illegal_op <= 1'b1;
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (wb_ctrl.valid && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
      if ((stall | flush) && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_wb_pipe.sv
// Directed table-driven bench for ctrl_wb_pipe plus hand-written reset sequences.
module tb_ctrl_wb_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic       id_reg_signal_write, id_mem_signal_write;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic [7:0] ex_result, ex_store_data, ex_mem_addr, mem_rdata;
  logic       stall, flush;
  logic       mem_we, rf_we, hazard, illegal_op;
  logic [7:0] mem_addr, mem_wdata, rf_wdata;
  logic [2:0] rf_waddr;
`ifdef PIPE_PERF_EN
  logic [15:0] retired_cnt, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_wb_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_reg_signal_write(id_reg_signal_write), .id_mem_signal_write(id_mem_signal_write),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_mem_addr(ex_mem_addr),
    .mem_rdata(mem_rdata), .stall(stall), .flush(flush),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hazard(hazard),
`ifdef PIPE_PERF_EN
    .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt),
`endif
    .illegal_op(illegal_op)
  );

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic       rw, mw;
    logic [2:0] rd, rs1, rs2;
    logic [7:0] res, sd, addr, rdata;
    logic       stall, flush;
    logic       e_mwe;
    logic [7:0] e_maddr, e_mwdata;
    logic       e_rwe;
    logic [2:0] e_waddr;
    logic [7:0] e_wdata;
    logic       e_haz, e_ill;
    int         e_ret, e_bub;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic logic [30:0] outs_now();
    return {mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata, hazard, illegal_op};
  endfunction

  task automatic drive_zero();
    id_valid = 0; id_opcode = 0; id_reg_signal_write = 0; id_mem_signal_write = 0;
    id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    ex_result = 0; ex_store_data = 0; ex_mem_addr = 0; mem_rdata = 0;
    stall = 0; flush = 0;
  endtask

  task automatic check_outs(input string name, input logic [30:0] exp);
    logic [30:0] act;
    act = outs_now();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {mwe,maddr,mwdata,rwe,waddr,wdata,haz,ill}=%h want %h", name, act, exp);
    end
  endtask

  task automatic check_strobes(input string name);
    tests++;
    if (mem_we !== 1'b0 || rf_we !== 1'b0) begin
      fails++;
      $display("FAIL %s: got mem_we=%b rf_we=%b want 0 0", name, mem_we, rf_we);
    end
  endtask

  initial begin
    //             v  op    rw mw rd rs1 rs2 res    sd     addr   rdata  st fl | mwe maddr  mwdata rwe wa wdata  hz il ret bub
    vecs[0]  = '{1, 4'h1, 0, 1, 0, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0}; // stm in ID
    vecs[1]  = '{1, 4'hA, 1, 0, 2, 3, 4, 8'h00, 8'hA5, 8'h10, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0}; // add rd2
    vecs[2]  = '{1, 4'h0, 1, 0, 3, 5, 5, 8'h7F, 8'h00, 8'h00, 8'h00, 0, 0,  1, 8'h10, 8'hA5, 0, 0, 8'h00, 0, 0, 0, 0}; // store strobe
    vecs[3]  = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0}; // stm in WB: no rf_we
    vecs[4]  = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h20, 8'h00, 1, 2, 8'h7F, 0, 0, 1, 0}; // add retires
    vecs[5]  = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h3C, 0, 0,  0, 8'h00, 8'h00, 1, 3, 8'h3C, 0, 0, 2, 0}; // load retires
    vecs[6]  = '{1, 4'hA, 1, 0, 2, 6, 7, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 3, 0}; // producer rd2
    vecs[7]  = '{1, 4'hB, 1, 0, 5, 2, 0, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 3, 0}; // hazard vs EX
    vecs[8]  = '{1, 4'hB, 1, 0, 5, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 3, 1}; // hazard vs MEM
    vecs[9]  = '{1, 4'hB, 1, 0, 5, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 1, 2, 8'h55, 0, 0, 3, 2}; // producer in WB
    vecs[10] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'hAA, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4, 2};
    vecs[11] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 4, 2};
    vecs[12] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 1, 5, 8'hAA, 0, 0, 4, 2}; // consumer retires
    vecs[13] = '{1, 4'hA, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 5, 2}; // A rd1
    vecs[14] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 5, 2};
    vecs[15] = '{1, 4'h1, 0, 1, 6, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 5, 2}; // C stm
    vecs[16] = '{1, 4'hA, 1, 0, 7, 0, 0, 8'h00, 8'h99, 8'h30, 8'h00, 1, 1,  0, 8'h00, 8'h00, 1, 1, 8'h11, 0, 0, 5, 2}; // flush+stall, A retires
    vecs[17] = '{1, 4'hE, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 6, 3}; // C/D killed; illegal in ID
    vecs[18] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 6, 3};
    vecs[19] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 6, 3};
    vecs[20] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 6, 3}; // illegal NOP in WB
    vecs[21] = '{0, 4'h0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 7, 3};

    drive_zero();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset_state", '0);

    // Reset while a store sits in EX: it must never reach mem_we.
    rst_n = 1'b1;
    @(negedge clk);
    id_valid = 1; id_opcode = 4'h1; id_mem_signal_write = 1;
    @(negedge clk);
    drive_zero();
    ex_store_data = 8'hA5; ex_mem_addr = 8'h10;
    #1 rst_n = 1'b0;
    #1 check_outs("async_reset_inflight", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outs("after_reset_release", '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check_strobes($sformatf("no_write_after_reset_%0d", k));
    end

    @(negedge clk);
    drive_zero();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      logic [30:0] exp;
      logic        bad;
      @(negedge clk);
      id_valid = vecs[i].v; id_opcode = vecs[i].op;
      id_reg_signal_write = vecs[i].rw; id_mem_signal_write = vecs[i].mw;
      id_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      ex_result = vecs[i].res; ex_store_data = vecs[i].sd; ex_mem_addr = vecs[i].addr;
      mem_rdata = vecs[i].rdata; stall = vecs[i].stall; flush = vecs[i].flush;
      #1;
      exp = {vecs[i].e_mwe, vecs[i].e_maddr, vecs[i].e_mwdata, vecs[i].e_rwe,
             vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_haz, vecs[i].e_ill};
      bad = (outs_now() !== exp);
`ifdef PIPE_PERF_EN
      if (retired_cnt !== 16'(vecs[i].e_ret) || bubble_cnt !== 16'(vecs[i].e_bub)) begin
        bad = 1'b1;
        $display("FAIL row%0d counters: got ret=%0d bub=%0d want ret=%0d bub=%0d",
                 i, retired_cnt, bubble_cnt, vecs[i].e_ret, vecs[i].e_bub);
      end
`endif
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL row%0d: got {mwe,maddr,mwdata,rwe,waddr,wdata,haz,ill}=%h want %h",
                 i, outs_now(), exp);
      end
    end

    @(negedge clk);
    drive_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_wb_pipe.md
Name: ctrl_wb_pipe

Overview:
- Back end of the control path: consumes per-instruction reg_signal_write / mem_signal_write produced by the opcode decoder in ID.
- Carries those signals, with destination and data, through EX, MEM and WB pipeline registers.
- Issues the data-memory write strobe in MEM and the register-file write strobe in WB.
- Flags RAW hazards back to ID. The processor is branch-free, so this block does no branch handling.

Parameters:
DATA_W, 8, datapath width
REG_ADDR_W, 3, register-file address width
MEM_ADDR_W, 8, data-memory address width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  4  opcode of the ID instruction
id_reg_signal_write  in  1  decoder register-write signal
id_mem_signal_write  in  1  decoder memory-write signal
id_rd  in  REG_ADDR_W  destination register
id_rs1  in  REG_ADDR_W  source register 1
id_rs2  in  REG_ADDR_W  source register 2
ex_result  in  DATA_W  ALU result of the EX-stage instruction (combinational)
ex_store_data  in  DATA_W  store data of the EX-stage instruction
ex_mem_addr  in  MEM_ADDR_W  memory address of the EX-stage instruction
mem_rdata  in  DATA_W  data-memory read data, 1-cycle synchronous read
stall  in  1  insert a bubble into EX
flush  in  1  kill EX and MEM contents
mem_we  out  1  data-memory write strobe
mem_addr  out  MEM_ADDR_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
rf_we  out  1  register-file write strobe
rf_waddr  out  REG_ADDR_W  register-file write address
rf_wdata  out  DATA_W  register-file write data
hazard  out  1  RAW hazard on the ID instruction
illegal_op  out  1  sticky undecoded-opcode flag

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits 0, all stored fields 0, illegal_op 0. Consequently mem_we=0, rf_we=0, mem_addr=0, mem_wdata=0, rf_waddr=0, rf_wdata=0 and hazard=0. Reset mid-operation discards every in-flight instruction; nothing is written afterwards.
- EX register, each clock:
  - flush=1: ex_valid<=0. Flush has priority over stall.
  - Otherwise stall=1: ex_valid<=0 (bubble). ID holding is external.
  - Otherwise: captures id_valid, opcode, rd, rs1, rs2 and both write signals.
- Undecoded opcodes (id_opcode[3:1]=3'b111): captured as a NOP with both write signals forced to 0, never X. illegal_op sets if id_valid=1, and stays set until reset.
- MEM register, each clock: captures the EX fields plus ex_result, ex_store_data and ex_mem_addr. flush=1 sets mem_valid<=0.
- WB register, each clock: captures the MEM fields. Never flushed.
- mem_we = mem_valid & mem_wr, driven combinationally from the MEM register. mem_addr and mem_wdata come from the MEM register.
- Loads: is_load = (opcode==4'b0000). Read data arrives one cycle after the address, i.e. while the load sits in WB.
  - rf_wdata = wb_is_load ? mem_rdata : wb_result.
  - rf_we = wb_valid & wb_reg_wr.
  - rf_waddr = wb_rd.
- Latency: ID capture to mem_we takes 2 clocks; ID capture to rf_we takes 3 clocks.
- hazard, combinational: id_valid & ((ex_valid&ex_reg_wr & (ex_rd==id_rs1 | ex_rd==id_rs2)) | (same test against MEM)).
  - The register file is write-through, so WB is not compared.
  - Register 0 is not special.
  - The top level feeds hazard into stall.
- Stall and flush asserted together: EX and MEM are cleared; WB still retires.

Optional Feature:
- Macro PIPE_PERF_EN.
- When defined: adds output ports retired_cnt[15:0] and bubble_cnt[15:0], both reset to 0.
  - retired_cnt increments once per cycle with wb_valid=1.
  - bubble_cnt increments once per cycle in which EX loads a bubble because of stall or flush.
  - Both saturate at 16'hFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ctrl_pkg:
  - opcode class constants, 3-bit: MEM_DATA, REG_DATA, ANDOR, NOTXOR, SHIFT, ADDSUB, DIV.
  - OP_LDM=4'b0000 and OP_STM=4'b0001.
  - Pipeline-control record typedef: valid, reg_wr, mem_wr, is_load, rd.
- One sub-module, pipe_stage_reg: a parameterised-width register with async clear, load enable and synchronous kill, instantiated three times.

Test Plan:
- Reset during an in-flight stm: assert rst_n=0 while the stm is in EX -> mem_we stays 0 and all outputs read 0 the cycle after reset.
- Store: stm (4'b0001) with addr 8'h10, data 8'hA5 -> mem_we=1, mem_addr=8'h10, mem_wdata=8'hA5 exactly 2 clocks after ID capture; rf_we never asserts.
- Load: ldm (4'b0000) to rd=3, mem_rdata=8'h3C during WB -> rf_we=1, rf_waddr=3, rf_wdata=8'h3C 3 clocks after capture.
- ALU result: add writes rd=2 with ex_result=8'h7F -> rf_wdata=8'h7F.
- RAW hazard: add to rd=2 followed by an instruction reading rs1=2 -> hazard=1 while the producer is in EX and in MEM, then 0; stall yields two bubbles, and bubble_cnt=2 when PIPE_PERF_EN is defined.
- Flush and illegal opcode: flush with instructions in EX and MEM -> neither writes, while the WB instruction still retires; opcode 4'b1110 with id_valid=1 -> illegal_op=1 (sticky), no writes.
